mips_lsu: RTL

MIPS_LSU -- requirements
Module: mips_lsu

---
 rtl/mips_lsu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - MIPS load/store unit with big-endian lanes, LL/SC reservation and ack timeout
module mips_lsu #(
    parameter int ADDR_W      = 32,
    parameter int GRAN_LOG2   = 2,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              resp_valid,
    output logic              resp_we,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              inval_valid,
    input  logic [ADDR_W-1:0] inval_addr,
    output logic              misalign,
    output logic              bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              TAG_W     = ADDR_W - GRAN_LOG2;
    localparam logic [31:0]     TMO_LAST  = 32'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((64'd1 << GRAN_LOG2) - 64'd1);
    localparam logic [ADDR_W-1:0] GRAN_MASK = ~LOW_MASK;

    logic [1:0]       state;
    logic [31:0]      tmo_cnt;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;

    logic       r_load, r_ll, r_sc, r_byte, r_half, r_signed;
    logic [1:0] r_off;
    logic [4:0] r_rd;

    logic is_load, is_store, is_sc, is_ll, is_byte, is_half, is_signed;
    logic legal, misaligned, idle_req, accept, sc_ok;
    logic ack_ok, tmo_hit, own_store_hit, inval_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_sc     = 1'b0;
        is_ll     = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (req_op)
            4'd0:  begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            4'd1:  begin is_load = 1'b1; is_byte = 1'b1; end
            4'd2:  begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            4'd3:  begin is_load = 1'b1; is_half = 1'b1; end
            4'd4:  is_load = 1'b1;
            4'd5:  begin is_load = 1'b1; is_ll = 1'b1; end
            4'd8:  begin is_store = 1'b1; is_byte = 1'b1; end
            4'd9:  begin is_store = 1'b1; is_half = 1'b1; end
            4'd10: is_store = 1'b1;
            4'd11: is_sc = 1'b1;
            default: ;
        endcase
    end

    assign legal      = is_load | is_store | is_sc;
    assign misaligned = (is_half & req_addr[0]) | (~is_byte & ~is_half & (|req_addr[1:0]));
    assign idle_req   = (state == S_IDLE) & req_valid & legal;
    assign accept     = en & idle_req & ~misaligned;
    assign sc_ok      = res_valid & (req_addr[ADDR_W-1:GRAN_LOG2] == res_tag);

    // Reset gates the combinational outputs so they fall with rst_n, not at the next edge.
    assign stall    = rst_n & ((idle_req & ~misaligned) | (state == S_REQ));
    assign misalign = rst_n & en & idle_req & misaligned;
    assign mem_req  = (state == S_REQ);

    assign ack_ok        = (state == S_REQ) & en & mem_ack;
    assign tmo_hit       = (ACK_TIMEOUT != 0) & (state == S_REQ) & en & ~mem_ack & (tmo_cnt == TMO_LAST);
    assign own_store_hit = ack_ok & mem_we & (mem_addr[ADDR_W-1:GRAN_LOG2] == res_tag);
    assign inval_hit     = inval_valid & ((inval_addr & GRAN_MASK) == {res_tag, {GRAN_LOG2{1'b0}}});

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        if (is_byte) begin
            st_be    = 4'b1000 >> req_addr[1:0];
            st_wdata = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            st_be    = req_addr[1] ? 4'b0011 : 4'b1100;
            st_wdata = {2{req_wdata[15:0]}};
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (r_off)
            2'd0: ld_byte = mem_rdata[31:24];
            2'd1: ld_byte = mem_rdata[23:16];
            2'd2: ld_byte = mem_rdata[15:8];
            2'd3: ld_byte = mem_rdata[7:0];
            default: ;
        endcase
        ld_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        ld_data = mem_rdata;
        if (r_byte)
            ld_data = {{24{r_signed & ld_byte[7]}}, ld_byte};
        else if (r_half)
            ld_data = {{16{r_signed & ld_half[15]}}, ld_half};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tmo_cnt    <= 32'd0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rd    <= 5'd0;
            resp_data  <= 32'd0;
            mem_we     <= 1'b0;
            mem_be     <= 4'd0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            bus_err    <= 1'b0;
            r_load     <= 1'b0;
            r_ll       <= 1'b0;
            r_sc       <= 1'b0;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_signed   <= 1'b0;
            r_off      <= 2'd0;
            r_rd       <= 5'd0;
        end else if (en) begin
            resp_valid <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_sc && !sc_ok) begin
                            // Failed SC never touches memory.
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_we    <= 1'b1;
                            resp_rd    <= req_rd;
                            resp_data  <= 32'd0;
                        end else begin
                            state     <= S_REQ;
                            tmo_cnt   <= 32'd0;
                            mem_we    <= is_store | is_sc;
                            mem_be    <= is_load ? 4'b1111 : st_be;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= is_load ? 32'd0 : st_wdata;
                            r_load    <= is_load;
                            r_ll      <= is_ll;
                            r_sc      <= is_sc;
                            r_byte    <= is_byte;
                            r_half    <= is_half;
                            r_signed  <= is_signed;
                            r_off     <= req_addr[1:0];
                            r_rd      <= req_rd;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_we    <= r_load | r_sc;
                        resp_rd    <= r_rd;
                        resp_data  <= r_sc ? 32'd1 : (r_load ? ld_data : 32'd0);
                    end else if (tmo_hit) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_we    <= 1'b0;
                        resp_rd    <= r_rd;
                        resp_data  <= 32'd0;
                        bus_err    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A completing LL outranks any same-cycle invalidation.
            if (ack_ok && r_ll) begin
                res_valid <= 1'b1;
                res_tag   <= mem_addr[ADDR_W-1:GRAN_LOG2];
            end else if ((ack_ok && r_sc) || own_store_hit || inval_hit) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
